// File: rtl/id_ex_stage_register.sv
// -----------------------------------------------------------------------------
// id_ex_stage_register
//
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// When the instruction in EX is a load whose destination is read by the
// instruction in ID, the stage raises a combinational stall (freezing PC and
// IF/ID) and loads a bubble into EX instead of the ID instruction. A flush
// (EX-resolved redirect) kills the ID instruction and overrides the hazard.
// Every bubble inserted for a hazard is counted in a saturating counter.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   id_valid          ID holds a real instruction
//   id_pc             PC of the ID instruction
//   id_rs1/rs2/rd     register indices of the ID instruction
//   id_uses_rs1/rs2   ID instruction actually reads rs1/rs2
//   id_rs1/rs2_data   register file read data
//   id_imm            decoded immediate
//   id_ctrl           control bundle: bit0 reg_write, bit1 mem_read,
//                     bit2 mem_write, upper bits passed through
//   flush             kill the ID instruction this cycle
//   stall             combinational; hold PC and IF/ID
//   ex_*              registered EX-stage copies of the ID fields
//   bubble_count      registered count of load-use bubbles since reset
// -----------------------------------------------------------------------------
module id_ex_stage_register #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  bubble_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              valid_q,    valid_d;
  logic [XLEN-1:0]   pc_q,       pc_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q,      imm_d;
  logic [4:0]        rs1_q,      rs1_d;
  logic [4:0]        rs2_q,      rs2_d;
  logic [4:0]        rd_q,       rd_d;
  logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
  logic [CNT_W-1:0]  count_q,    count_d;

  logic rs1_match_s;
  logic rs2_match_s;
  logic hazard_s;

  // Load-use detection: compares the ID sources against the load now in EX.
  // Only sources the instruction really reads can match, and x0 never does.
  always_comb begin
    rs1_match_s = id_uses_rs1 && (id_rs1 == rd_q);
    rs2_match_s = id_uses_rs2 && (id_rs2 == rd_q);
    hazard_s    = valid_q && ctrl_q[1] && (rd_q != 5'd0) && id_valid
                  && (rs1_match_s || rs2_match_s);
    // A redirect kills the dependent instruction, so there is nothing to hold.
    stall       = hazard_s && !flush;
  end

  // Next-state selection: flush bubble, hazard bubble, or load the ID fields.
  always_comb begin
    valid_d    = 1'b0;
    pc_d       = {XLEN{1'b0}};
    rs1_data_d = {XLEN{1'b0}};
    rs2_data_d = {XLEN{1'b0}};
    imm_d      = {XLEN{1'b0}};
    rs1_d      = 5'd0;
    rs2_d      = 5'd0;
    rd_d       = 5'd0;
    ctrl_d     = {CTRL_W{1'b0}};
    count_d    = count_q;
    if (flush) begin
      // Bubble from the defaults; redirects are not performance bubbles.
      count_d = count_q;
    end else if (hazard_s) begin
      if (count_q != CNT_MAX) begin
        count_d = count_q + CNT_ONE;
      end else begin
        count_d = count_q;
      end
    end else begin
      valid_d    = id_valid;
      pc_d       = id_pc;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      // Zero indices on an empty slot keep the forwarding unit from matching it.
      if (id_valid) begin
        rs1_d  = id_rs1;
        rs2_d  = id_rs2;
        rd_d   = id_rd;
        ctrl_d = id_ctrl;
      end else begin
        rs1_d  = 5'd0;
        rs2_d  = 5'd0;
        rd_d   = 5'd0;
        ctrl_d = {CTRL_W{1'b0}};
      end
    end
  end

  // Pipeline register and bubble counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      pc_q       <= {XLEN{1'b0}};
      rs1_data_q <= {XLEN{1'b0}};
      rs2_data_q <= {XLEN{1'b0}};
      imm_q      <= {XLEN{1'b0}};
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      rd_q       <= 5'd0;
      ctrl_q     <= {CTRL_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
      count_q    <= count_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_pc        = pc_q;
  assign ex_rs1_data  = rs1_data_q;
  assign ex_rs2_data  = rs2_data_q;
  assign ex_imm       = imm_q;
  assign ex_rs1       = rs1_q;
  assign ex_rs2       = rs2_q;
  assign ex_rd        = rd_q;
  assign ex_ctrl      = ctrl_q;
  assign bubble_count = count_q;

endmodule

// File: tb/tb_id_ex_stage_register.sv
module tb_id_ex_stage_register;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic              id_uses_rs1, id_uses_rs2;
  logic [CTRL_W-1:0] id_ctrl;
  logic              flush;

  logic              stall, ex_valid;
  logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  bubble_count;

  // second instance with a 2-bit counter to reach saturation quickly
  logic              s_stall, s_ex_valid;
  logic [XLEN-1:0]   s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
  logic [4:0]        s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic [CTRL_W-1:0] s_ex_ctrl;
  logic [1:0]        s_bubble_count;

  int n_cmp = 0;
  int n_err = 0;

  // reference model of the EX slot
  bit              m_valid;
  bit [XLEN-1:0]   m_pc, m_rs1_data, m_rs2_data, m_imm;
  bit [4:0]        m_rs1, m_rs2, m_rd;
  bit [CTRL_W-1:0] m_ctrl;
  longint          m_cnt;
  int              m_cnt2;

  always #5 clk = ~clk;

  id_ex_stage_register #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .flush(flush), .stall(stall), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .bubble_count(bubble_count)
  );

  id_ex_stage_register #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .flush(flush), .stall(s_stall), .ex_valid(s_ex_valid),
    .ex_pc(s_ex_pc), .ex_rs1_data(s_ex_rs1_data), .ex_rs2_data(s_ex_rs2_data),
    .ex_imm(s_ex_imm), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd),
    .ex_ctrl(s_ex_ctrl), .bubble_count(s_bubble_count)
  );

  function automatic bit exp_hazard();
    bit dep;
    dep = (id_uses_rs1 && id_rs1 == m_rd) || (id_uses_rs2 && id_rs2 == m_rd);
    return m_valid && m_ctrl[1] && (m_rd != 5'd0) && id_valid && dep;
  endfunction

  function automatic bit exp_stall();
    return exp_hazard() && !flush;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_pc = '0; m_rs1_data = '0; m_rs2_data = '0; m_imm = '0;
    m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic drive(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                       input bit [4:0] rd, input bit u1, input bit u2,
                       input bit [CTRL_W-1:0] ctrl, input bit fl);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_ctrl = ctrl; flush = fl;
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
  endtask

  // one clock edge; model computes the EX contents from the pre-edge inputs
  task automatic step();
    bit hz, fl, v;
    bit [XLEN-1:0] pc, d1, d2, im;
    bit [4:0] r1, r2, rd;
    bit [CTRL_W-1:0] c;
    hz = exp_hazard(); fl = flush; v = id_valid;
    pc = id_pc; d1 = id_rs1_data; d2 = id_rs2_data; im = id_imm;
    r1 = id_rs1; r2 = id_rs2; rd = id_rd; c = id_ctrl;
    @(posedge clk);
    #1;
    if (fl || hz) begin
      m_valid = 1'b0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0;
      if (!fl) begin
        m_cnt  = m_cnt + 1;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
    end else begin
      m_valid = v; m_pc = pc; m_rs1_data = d1; m_rs2_data = d2; m_imm = im;
      m_rs1 = v ? r1 : 5'd0; m_rs2 = v ? r2 : 5'd0;
      m_rd  = v ? rd : 5'd0; m_ctrl = v ? c : '0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 8'h03, 1'b0);
    #1;
    model_reset();
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", ex_valid); end
    n_cmp++; if (ex_ctrl !== 8'h00) begin n_err++; $display("FAIL reset_ctrl: got %0h want 0", ex_ctrl); end
    n_cmp++; if (ex_rd !== 5'd0) begin n_err++; $display("FAIL reset_rd: got %0d want 0", ex_rd); end
    n_cmp++; if (ex_pc !== 32'd0) begin n_err++; $display("FAIL reset_pc: got %0h want 0", ex_pc); end
    n_cmp++; if (bubble_count !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bubble_count); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %0b want 0", stall); end
    @(negedge clk);
    reset = 1'b0;
    step();
    n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL post_reset_valid: got %0b want 1", ex_valid); end
    n_cmp++; if (ex_rd !== 5'd3) begin n_err++; $display("FAIL post_reset_rd: got %0d want 3", ex_rd); end
    n_cmp++; if (ex_pc !== m_pc) begin n_err++; $display("FAIL post_reset_pc: got %0h want %0h", ex_pc, m_pc); end
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 8'h03, 1'b0);   // lw x5
    step();
    drive(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 8'h01, 1'b0);   // add x6,x5,x1
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %0b want 1", stall); end
    step();
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble_valid: got %0b want 0", ex_valid); end
    n_cmp++; if (ex_ctrl !== 8'h00) begin n_err++; $display("FAIL lu_bubble_ctrl: got %0h want 0", ex_ctrl); end
    n_cmp++; if (bubble_count !== 32'd1) begin n_err++; $display("FAIL lu_count: got %0d want 1", bubble_count); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_clear: got %0b want 0", stall); end
    step();
    n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_rs1 !== 5'd5)
      begin n_err++; $display("FAIL lu_add_enters: got v=%0b rd=%0d rs1=%0d want v=1 rd=6 rs1=5", ex_valid, ex_rd, ex_rs1); end
    n_cmp++; if (bubble_count !== 32'd1) begin n_err++; $display("FAIL lu_count_hold: got %0d want 1", bubble_count); end
  endtask

  task automatic test_no_stall_cases();
    drive(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 8'h03, 1'b0);   // lw x0
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 8'h01, 1'b0);   // add x6,x0,x0
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL x0_stall: got %0b want 0", stall); end
    step();
    drive(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 8'h03, 1'b0);   // lw x5
    step();
    drive(1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 8'h01, 1'b0);   // lui x5
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL unused_src_stall: got %0b want 0", stall); end
    step();
    n_cmp++; if (ex_valid !== 1'b1 || bubble_count !== m_cnt[31:0])
      begin n_err++; $display("FAIL unused_src_load: got v=%0b cnt=%0d want v=1 cnt=%0d", ex_valid, bubble_count, m_cnt); end
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 8'h03, 1'b0);
    step();
    drive(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 8'h01, 1'b1);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %0b want 0", stall); end
    step();
    n_cmp++; if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || ex_rd !== 5'd0)
      begin n_err++; $display("FAIL flush_bubble: got v=%0b ctrl=%0h rd=%0d want 0/0/0", ex_valid, ex_ctrl, ex_rd); end
    n_cmp++; if (bubble_count !== 32'd1) begin n_err++; $display("FAIL flush_count: got %0d want 1", bubble_count); end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
  endtask

  task automatic test_alu_no_stall();
    drive(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 8'h01, 1'b0);   // add x5
    step();
    drive(1'b1, 5'd5, 5'd5, 5'd7, 1'b1, 1'b1, 8'h01, 1'b0);   // sub x7,x5,x5
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu_stall: got %0b want 0", stall); end
    step();
    n_cmp++; if (ex_rs1 !== 5'd5 || ex_rs2 !== 5'd5 || ex_rd !== 5'd7)
      begin n_err++; $display("FAIL alu_indices: got rs1=%0d rs2=%0d rd=%0d want 5/5/7", ex_rs1, ex_rs2, ex_rd); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 8'h03, 1'b0);
      step();
      drive(1'b1, 5'd1, 5'd5, 5'd6, 1'b0, 1'b1, 8'h01, 1'b0);
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL sat_stall_%0d: got %0b want 1", k, stall); end
      step();
      n_cmp++; if (s_bubble_count !== m_cnt2[1:0]) begin n_err++; $display("FAIL sat_count_%0d: got %0d want %0d", k, s_bubble_count, m_cnt2); end
    end
    n_cmp++; if (s_bubble_count !== 2'd3) begin n_err++; $display("FAIL sat_final: got %0d want 3", s_bubble_count); end
    n_cmp++; if (bubble_count !== 32'd5) begin n_err++; $display("FAIL wide_count: got %0d want 5", bubble_count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, 5'($urandom % 4), 5'($urandom % 4), 5'($urandom % 4),
            1'($urandom), 1'($urandom), 8'($urandom), ($urandom % 8) == 0);
      #1;
      n_cmp++; if (stall !== exp_stall()) begin n_err++; $display("FAIL rnd_stall[%0d]: got %0b want %0b", i, stall, exp_stall()); end
      step();
      n_cmp++;
      if (ex_valid !== m_valid || ex_rd !== m_rd || ex_rs1 !== m_rs1 || ex_rs2 !== m_rs2 || ex_ctrl !== m_ctrl) begin
        n_err++;
        $display("FAIL rnd_ex[%0d]: got v=%0b rd=%0d rs1=%0d rs2=%0d ctrl=%0h want v=%0b rd=%0d rs1=%0d rs2=%0d ctrl=%0h",
                 i, ex_valid, ex_rd, ex_rs1, ex_rs2, ex_ctrl, m_valid, m_rd, m_rs1, m_rs2, m_ctrl);
      end
      if (m_valid) begin
        n_cmp++;
        if (ex_pc !== m_pc || ex_rs1_data !== m_rs1_data || ex_rs2_data !== m_rs2_data || ex_imm !== m_imm) begin
          n_err++;
          $display("FAIL rnd_data[%0d]: got pc=%0h d1=%0h d2=%0h imm=%0h want %0h %0h %0h %0h",
                   i, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, m_pc, m_rs1_data, m_rs2_data, m_imm);
        end
      end
      n_cmp++;
      if (bubble_count !== m_cnt[31:0] || s_bubble_count !== m_cnt2[1:0]) begin
        n_err++;
        $display("FAIL rnd_count[%0d]: got %0d/%0d want %0d/%0d", i, bubble_count, s_bubble_count, m_cnt, m_cnt2);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 5'd2, 5'd0, 5'd9, 1'b1, 1'b0, 8'h03, 1'b0);
    step();
    drive(1'b1, 5'd9, 5'd1, 5'd4, 1'b1, 1'b1, 8'h01, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL mid_pre_stall: got %0b want 1", stall); end
    reset = 1'b1;
    #1;
    model_reset();
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL mid_stall_drop: got %0b want 0", stall); end
    n_cmp++; if (bubble_count !== 32'd0 || s_bubble_count !== 2'd0)
      begin n_err++; $display("FAIL mid_count_clear: got %0d/%0d want 0/0", bubble_count, s_bubble_count); end
    #1;
    reset = 1'b0;
    step();
    n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd4 || bubble_count !== 32'd0)
      begin n_err++; $display("FAIL mid_after: got v=%0b rd=%0d cnt=%0d want 1/4/0", ex_valid, ex_rd, bubble_count); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall_cases();
    test_flush();
    test_alu_no_stall();
    test_saturation();
    test_random();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
